// File: rtl/screen_sequencer_pkg.sv
// Shared types for the screen sequencer.
//   screen_t : screen currently driving the VGA outputs (also the screen_sel encoding)
//   COLOR_W  : default bits per colour channel
//   RGB_W    : width of a packed {R,G,B} pixel at the default channel width
package screen_pkg;

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    PLAYING = 2'd1,
    VICTORY = 2'd2,
    DEFEAT  = 2'd3
  } screen_t;

  localparam int unsigned COLOR_W = 8;
  localparam int unsigned RGB_W   = 3 * COLOR_W;

endpackage

// File: rtl/screen_sequencer_sync_rise.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   async_i : asynchronous level input
//   rise_o  : one-cycle pulse on each synchronized 0->1 transition
module sync_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/screen_sequencer.sv
// Game-level screen controller. Chooses which pixel source (attract, game field,
// victory, defeat) drives the DAC, switching only on frame boundaries, and gates /
// resets the game logic.
//   clk          : pixel clock
//   reset        : asynchronous active-low reset
//   frame_start  : one-cycle pulse at pixel (0,0)
//   start_btn    : raw asynchronous start key, active-high
//   win_evt      : one-cycle pulse, player won
//   lose_evt     : one-cycle pulse, player lost
//   game_rgb     : {R,G,B} from the game-field generator
//   win_rgb      : {R,G,B} from the victory-screen generator
//   lose_rgb     : {R,G,B} from the defeat-screen generator
//   R, G, B      : registered colour to the DAC
//   screen_sel   : current screen (screen_t encoding)
//   game_enable  : high only while PLAYING
//   game_reset   : one-cycle pulse on entry to PLAYING
module screen_sequencer #(
  parameter int unsigned HOLD_FRAMES  = 180,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned COLOR_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   start_btn,
  input  logic                   win_evt,
  input  logic                   lose_evt,
  input  logic [3*COLOR_W-1:0]   game_rgb,
  input  logic [3*COLOR_W-1:0]   win_rgb,
  input  logic [3*COLOR_W-1:0]   lose_rgb,
  output logic [COLOR_W-1:0]     R,
  output logic [COLOR_W-1:0]     G,
  output logic [COLOR_W-1:0]     B,
  output logic [1:0]             screen_sel,
  output logic                   game_enable,
  output logic                   game_reset
);

  import screen_pkg::*;

  localparam int unsigned PIX_W  = 3 * COLOR_W;
  localparam int unsigned FCNT_W = $clog2(HOLD_FRAMES) + 1;
  localparam int unsigned BCNT_W = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FCNT_W-1:0] HOLD_LAST  = FCNT_W'(HOLD_FRAMES - 1);
  localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_FRAMES - 1);

  screen_t           state_q,      state_d;
  logic [FCNT_W-1:0] frame_cnt_q,  frame_cnt_d;
  logic [BCNT_W-1:0] blink_cnt_q,  blink_cnt_d;
  logic              blink_on_q,   blink_on_d;
  logic              start_pend_q, start_pend_d;
  logic              win_pend_q,   win_pend_d;
  logic              lose_pend_q,  lose_pend_d;
  logic              game_en_q;
  logic              game_rst_q,   game_rst_d;
  logic [PIX_W-1:0]  rgb_q,        rgb_d;
  logic              start_rise;

  sync_rise u_start_sync (
    .clk_i   (clk),
    .rst_ni  (reset),
    .async_i (start_btn),
    .rise_o  (start_rise)
  );

  // Every frame_start consumes all pending flags; an event arriving in that same
  // cycle is kept for the following frame instead of being lost.
  always_comb begin
    if (frame_start) begin
      start_pend_d = start_rise;
      win_pend_d   = win_evt;
      lose_pend_d  = lose_evt;
    end else begin
      start_pend_d = start_pend_q | start_rise;
      win_pend_d   = win_pend_q   | win_evt;
      lose_pend_d  = lose_pend_q  | lose_evt;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;

    if (frame_start) begin
      case (state_q)
        ATTRACT: begin
          if (start_pend_q) begin
            state_d = PLAYING;
          end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BCNT_W'(1);
          end
        end
        PLAYING: begin
          if (win_pend_q) begin
            state_d = VICTORY;
          end else if (lose_pend_q) begin
            state_d = DEFEAT;
          end
        end
        VICTORY, DEFEAT: begin
          if (frame_cnt_q == HOLD_LAST) begin
            state_d = ATTRACT;
          end else if (frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          end
        end
        default: state_d = ATTRACT;
      endcase
    end

    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end
    // Re-entering ATTRACT always starts with the trophy visible.
    if ((state_d == ATTRACT) && (state_q != ATTRACT)) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end

    game_rst_d = (state_q == ATTRACT) && (state_d == PLAYING);

    // Mux follows the registered screen, so the pixel path lags screen_sel by one clock.
    rgb_d = '0;
    case (state_q)
      ATTRACT: rgb_d = blink_on_q ? win_rgb : '0;
      PLAYING: rgb_d = game_rgb;
      VICTORY: rgb_d = win_rgb;
      DEFEAT:  rgb_d = lose_rgb;
      default: rgb_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ATTRACT;
      frame_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      start_pend_q <= 1'b0;
      win_pend_q   <= 1'b0;
      lose_pend_q  <= 1'b0;
      game_en_q    <= 1'b0;
      game_rst_q   <= 1'b0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      start_pend_q <= start_pend_d;
      win_pend_q   <= win_pend_d;
      lose_pend_q  <= lose_pend_d;
      game_en_q    <= (state_d == PLAYING);
      game_rst_q   <= game_rst_d;
      rgb_q        <= rgb_d;
    end
  end

  assign R           = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign G           = rgb_q[2*COLOR_W-1:COLOR_W];
  assign B           = rgb_q[COLOR_W-1:0];
  assign screen_sel  = state_q;
  assign game_enable = game_en_q;
  assign game_reset  = game_rst_q;

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;
  import screen_pkg::*;

  localparam logic [RGB_W-1:0] GAME_PIX = 24'h102030;
  localparam logic [RGB_W-1:0] WIN_PIX  = 24'hA1B2C3;
  localparam logic [RGB_W-1:0] LOSE_PIX = 24'h0F0E0D;
  localparam logic [RGB_W-1:0] BLACK    = 24'h000000;

  logic               clk;
  logic               reset;
  logic               frame_start;
  logic               start_btn;
  logic               win_evt;
  logic               lose_evt;
  logic [RGB_W-1:0]   game_rgb;
  logic [RGB_W-1:0]   win_rgb;
  logic [RGB_W-1:0]   lose_rgb;
  logic [COLOR_W-1:0] R;
  logic [COLOR_W-1:0] G;
  logic [COLOR_W-1:0] B;
  logic [1:0]         screen_sel;
  logic               game_enable;
  logic               game_reset;

  screen_sequencer #(
    .HOLD_FRAMES  (4),
    .BLINK_FRAMES (2),
    .COLOR_W      (COLOR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .start_btn   (start_btn),
    .win_evt     (win_evt),
    .lose_evt    (lose_evt),
    .game_rgb    (game_rgb),
    .win_rgb     (win_rgb),
    .lose_rgb    (lose_rgb),
    .R           (R),
    .G           (G),
    .B           (B),
    .screen_sel  (screen_sel),
    .game_enable (game_enable),
    .game_reset  (game_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned      cyc;
    logic [1:0]       sel;
    logic             en;
    logic             rst;
    logic [RGB_W-1:0] rgb;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  function automatic void expect_at(int unsigned c, screen_t s, logic en, logic rs,
                                    logic [RGB_W-1:0] rgb);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.en  = en;
    e.rst = rs;
    e.rgb = rgb;
    sb.push_back(e);
  endfunction

  task automatic cmp(string name, int unsigned c, logic [RGB_W-1:0] act,
                     logic [RGB_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, c, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_check @cyc %0d: got none want sample", e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      cmp("screen_sel",  cyc, RGB_W'(screen_sel),  RGB_W'(e.sel));
      cmp("game_enable", cyc, RGB_W'(game_enable), RGB_W'(e.en));
      cmp("game_reset",  cyc, RGB_W'(game_reset),  RGB_W'(e.rst));
      cmp("rgb",         cyc, {R, G, B},            e.rgb);
    end
  end

  // One clock: inputs set here are sampled at edge cyc+1; frame_start at every 20th edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    win_evt     = 1'b0;
    lose_evt    = 1'b0;
    frame_start = ((cyc + 1) % 20) == 0;
  endtask

  task automatic run_to(int unsigned c);
    while (cyc < c) step();
  endtask

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    start_btn   = 1'b0;
    win_evt     = 1'b0;
    lose_evt    = 1'b0;
    game_rgb    = GAME_PIX;
    win_rgb     = WIN_PIX;
    lose_rgb    = LOSE_PIX;
    cyc         = 0;
    checks      = 0;
    errors      = 0;

    // Reset state.
    expect_at(0, ATTRACT, 1'b0, 1'b0, BLACK);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // 1: idle attract, blink toggles at edges 40, 80.
    expect_at(5,  ATTRACT, 1'b0, 1'b0, WIN_PIX);
    expect_at(40, ATTRACT, 1'b0, 1'b0, WIN_PIX);
    expect_at(45, ATTRACT, 1'b0, 1'b0, BLACK);
    expect_at(80, ATTRACT, 1'b0, 1'b0, BLACK);
    expect_at(85, ATTRACT, 1'b0, 1'b0, WIN_PIX);

    // 2: start mid-frame -> PLAYING after the frame_start at edge 100.
    expect_at(99,  ATTRACT, 1'b0, 1'b0, WIN_PIX);
    expect_at(100, PLAYING, 1'b1, 1'b1, WIN_PIX);
    expect_at(101, PLAYING, 1'b1, 1'b0, GAME_PIX);
    run_to(90);
    start_btn = 1'b1;
    run_to(95);
    start_btn = 1'b0;

    // 3 + 5: simultaneous win/lose -> VICTORY at 120, held 4 frames; start ignored.
    expect_at(119, PLAYING, 1'b1, 1'b0, GAME_PIX);
    expect_at(120, VICTORY, 1'b0, 1'b0, GAME_PIX);
    expect_at(121, VICTORY, 1'b0, 1'b0, WIN_PIX);
    expect_at(199, VICTORY, 1'b0, 1'b0, WIN_PIX);
    expect_at(200, ATTRACT, 1'b0, 1'b0, WIN_PIX);
    expect_at(201, ATTRACT, 1'b0, 1'b0, WIN_PIX);
    expect_at(220, ATTRACT, 1'b0, 1'b0, WIN_PIX);
    expect_at(241, ATTRACT, 1'b0, 1'b0, BLACK);
    run_to(110);
    win_evt  = 1'b1;
    lose_evt = 1'b1;
    run_to(150);
    start_btn = 1'b1;
    run_to(155);
    start_btn = 1'b0;

    // 4: back to PLAYING at 260; lose_evt coincident with frame_start at 280.
    expect_at(260, PLAYING, 1'b1, 1'b1, BLACK);
    expect_at(261, PLAYING, 1'b1, 1'b0, GAME_PIX);
    expect_at(280, PLAYING, 1'b1, 1'b0, GAME_PIX);
    expect_at(299, PLAYING, 1'b1, 1'b0, GAME_PIX);
    expect_at(300, DEFEAT,  1'b0, 1'b0, GAME_PIX);
    expect_at(301, DEFEAT,  1'b0, 1'b0, LOSE_PIX);
    run_to(250);
    start_btn = 1'b1;
    run_to(255);
    start_btn = 1'b0;
    run_to(279);
    lose_evt = 1'b1;

    // 6: DEFEAT ends at 380, PLAYING at 400, VICTORY at 420, reset mid-frame at 430.
    expect_at(400, PLAYING, 1'b1, 1'b1, WIN_PIX);
    expect_at(421, VICTORY, 1'b0, 1'b0, WIN_PIX);
    expect_at(430, ATTRACT, 1'b0, 1'b0, BLACK);
    expect_at(435, ATTRACT, 1'b0, 1'b0, WIN_PIX);
    expect_at(439, ATTRACT, 1'b0, 1'b0, WIN_PIX);
    expect_at(440, PLAYING, 1'b1, 1'b1, WIN_PIX);
    expect_at(441, PLAYING, 1'b1, 1'b0, GAME_PIX);
    run_to(385);
    start_btn = 1'b1;
    run_to(390);
    start_btn = 1'b0;
    run_to(409);
    win_evt = 1'b1;
    run_to(430);
    reset = 1'b0;
    run_to(432);
    reset = 1'b1;
    run_to(433);
    start_btn = 1'b1;
    run_to(438);
    start_btn = 1'b0;

    run_to(445);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL unchecked @cyc %0d: got none want sample", e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
